// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader state encoding and program memory placement shared by loader and memory.
package program_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;
  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;
endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: big-endian byte shift register with a 2-bit byte-in-word counter.
module word_assembler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [7:0]       value,
  output logic [WIDTH-1:0] word,
  output logic             last
);
  logic [1:0] count;
  assign last = count == 2'd3;
  always_ff @(posedge clk) begin
    if (!reset) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift) begin
      word  <= {word[WIDTH-9:0], value};
      count <= count + 2'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream and writes it as 32-bit words to program memory.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_write_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o
);
  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] count, index, len;
  logic        accept, restart, last;
  assign accept  = byte_valid_i && byte_ready_o;
  assign restart = start_i && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign len     = {len_hi, byte_i};
  word_assembler #(.WIDTH(DATA_WIDTH)) assembler (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .shift (accept && state == S_DATA),
    .value (byte_i),
    .word  (mem_data_o),
    .last  (last)
  );
  // Outputs are registered alongside the state, so each transition sets the flags of the state it enters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      byte_ready_o  <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_address_o <= BASE_ADDRESS;
      cpu_hold_o    <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      len_hi        <= '0;
      count         <= '0;
      index         <= '0;
    end else begin
      mem_write_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (restart) begin
          state         <= S_LEN_HI;
          byte_ready_o  <= 1'b1;
          cpu_hold_o    <= 1'b1;
          done_o        <= 1'b0;
          error_o       <= 1'b0;
          index         <= '0;
          mem_address_o <= BASE_ADDRESS;
        end
        S_LEN_HI: if (accept) begin
          len_hi <= byte_i;
          state  <= S_LEN_LO;
        end
        S_LEN_LO: if (accept) begin
          count <= len;
          if (len == 16'd0) begin
            state        <= S_DONE;
            byte_ready_o <= 1'b0;
            cpu_hold_o   <= 1'b0;
            done_o       <= 1'b1;
          end else if ({16'd0, len} > 32'(MEMORY_DEPTH)) begin
            state        <= S_ERROR;
            byte_ready_o <= 1'b0;
            error_o      <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (accept && last) begin
          state        <= S_WRITE;
          byte_ready_o <= 1'b0;
          mem_write_o  <= 1'b1;
        end
        S_WRITE: begin
          index         <= index + 16'd1;
          mem_address_o <= mem_address_o + DATA_WIDTH'(4);
          if (index == count - 16'd1) begin
            state      <= S_DONE;
            cpu_hold_o <= 1'b0;
            done_o     <= 1'b1;
          end else begin
            state        <= S_DATA;
            byte_ready_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed byte streams checked against a word-level scoreboard built from the stream.
module tb_program_loader;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  logic        clk = 1'b0, reset = 1'b0, start_i = 1'b0, byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_ready_o, mem_write_o, cpu_hold_o, done_o, error_o;
  logic [31:0] mem_address_o, mem_data_o;
  int          passed = 0, total = 0, cyc = 0, last_acc = -10, writes = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] exp_addr[$], exp_data[$];
  logic [7:0]  stream[$];
  logic        exp_done, exp_error;

  program_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .mem_write_o   (mem_write_o),
    .mem_address_o (mem_address_o),
    .mem_data_o    (mem_data_o),
    .cpu_hold_o    (cpu_hold_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Every strobe must match the next scoreboard word and follow the last accepted byte by one cycle.
  always @(negedge clk) if (mem_write_o !== 1'b0) begin
    writes++;
    if (exp_addr.size() == 0) begin
      total++;
      $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_address_o, mem_data_o);
    end else begin
      chk("write_addr", mem_address_o, exp_addr.pop_front());
      chk("write_data", mem_data_o, exp_data.pop_front());
      chk("write_latency", 32'(cyc), 32'(last_acc));
      last_addr = mem_address_o;
    end
  end

  task automatic model();
    int n;
    n = 256 * int'(stream[0]) + int'(stream[1]);
    exp_done  = n <= DEPTH;
    exp_error = n > DEPTH;
    if (n <= DEPTH)
      for (int w = 0; w < n; w++) begin
        exp_addr.push_back(BASE + 32'(4 * w));
        exp_data.push_back({stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]});
      end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      total++;
      $display("FAIL send_timeout: got byte_ready_o=0 for 100 cycles expected 1");
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_all();
    foreach (stream[i]) send(stream[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int t = 0;
    while (!(done_o || error_o) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_status"}, {30'd0, done_o, error_o}, {30'd0, exp_done, exp_error});
    chk({name, "_hold"}, 32'(cpu_hold_o), 32'(exp_error));
    chk({name, "_pending"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ready"}, 32'(byte_ready_o), 32'd0);
    chk({name, "_write"}, 32'(mem_write_o), 32'd0);
    chk({name, "_addr"}, mem_address_o, BASE);
    chk({name, "_data"}, mem_data_o, 32'd0);
    chk({name, "_flags"}, {29'd0, cpu_hold_o, done_o, error_o}, 32'd0);
  endtask

  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("idle");

    // Two-word program
    pulse_start();
    chk("start_ready", 32'(byte_ready_o), 32'd1);
    chk("start_hold", 32'(cpu_hold_o), 32'd1);
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    model();
    chk("model_data0", exp_data[0], 32'h2008_0005);
    chk("model_addr1", exp_addr[1], 32'h0040_0004);
    chk("model_data1", exp_data[1], 32'h0109_5020);
    w0 = writes;
    send_all();
    wait_end("two_words");
    chk("two_words_count", 32'(writes - w0), 32'd2);

    // Zero-length header finishes the cycle after the low length byte
    pulse_start();
    stream = '{8'h00, 8'h00};
    model();
    w0 = writes;
    send_all();
    chk("zero_done", 32'(done_o), 32'd1);
    chk("zero_hold", 32'(cpu_hold_o), 32'd0);
    wait_end("zero");
    chk("zero_count", 32'(writes - w0), 32'd0);

    // Oversized header stays in error until restarted
    pulse_start();
    stream = '{8'h00, 8'h41};
    model();
    send_all();
    repeat (4) @(negedge clk);
    wait_end("oversize");
    chk("oversize_ready", 32'(byte_ready_o), 32'd0);
    pulse_start();
    chk("restart_ready", 32'(byte_ready_o), 32'd1);
    chk("restart_flags", {30'd0, done_o, error_o}, 32'd0);
    chk("restart_hold", 32'(cpu_hold_o), 32'd1);

    // Valid gap mid-word with an ignored start pulse
    stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    model();
    chk("model_gap", exp_data[0], 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) send(stream[i]);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("gap_ready", 32'(byte_ready_o), 32'd1);
    chk("gap_done", 32'(done_o), 32'd0);
    send(stream[4]);
    send(stream[5]);
    wait_end("gap");

    // Full memory
    pulse_start();
    stream = '{8'h00, 8'h40};
    for (int i = 0; i < 256; i++) stream.push_back(8'(i * 7 + 3));
    model();
    chk("model_last_addr", exp_addr[63], 32'h0040_00FC);
    w0 = writes;
    send_all();
    wait_end("full");
    chk("full_count", 32'(writes - w0), 32'd64);
    chk("full_last_addr", last_addr, 32'h0040_00FC);

    // Reset during a partial word
    pulse_start();
    stream = '{8'h00, 8'h01, 8'h11, 8'h22};
    w0 = writes;
    send_all();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("abort");
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk_reset("after_abort");
    chk("abort_count", 32'(writes - w0), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
